// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory responder.
// Latency: n/a (types only).
// Backpressure: n/a.
package vmem_pkg;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_TAIL,
    RESP
  } vmem_state_t;

  // A vector access must start on a 16-byte boundary.
  function automatic logic misaligned(input logic [3:0] addr_lo);
    return addr_lo != 4'd0;
  endfunction

endpackage

// File: rtl/vmem_beat_buf.sv
// Vector staging buffers: store-data serializer and load-data assembler.
// Latency: select is combinational from the register; load/capture land next edge.
// Backpressure: none; the caller sequences beats.
module vmem_beat_buf
  import vmem_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int VEC_W  = WORD_W * BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wload_en,
  input  logic [VEC_W-1:0]  wload_dat,
  input  logic [BEAT_W-1:0] wsel_idx,
  output logic [WORD_W-1:0] wsel_dat,
  input  logic              cap_en,
  input  logic [BEAT_W-1:0] cap_idx,
  input  logic [WORD_W-1:0] cap_dat,
  output logic [VEC_W-1:0]  rbuf_dat
);

  logic [VEC_W-1:0] wbuf_q, wbuf_d;
  logic [VEC_W-1:0] rbuf_q, rbuf_d;

  // Next-value logic: whole-vector load for stores, one-word insert for load beats.
  always_comb begin
    wbuf_d = wbuf_q;
    rbuf_d = rbuf_q;
    if (wload_en) begin
      wbuf_d = wload_dat;
    end
    if (cap_en) begin
      rbuf_d[int'(cap_idx) * WORD_W +: WORD_W] = cap_dat;
    end
  end

  // Buffer registers; cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_q <= '0;
      rbuf_q <= '0;
    end else begin
      wbuf_q <= wbuf_d;
      rbuf_q <= rbuf_d;
    end
  end

  assign wsel_dat = wbuf_q[int'(wsel_idx) * WORD_W +: WORD_W];
  assign rbuf_dat = rbuf_q;

endmodule

// File: rtl/vmem_responder.sv
// Serializes one 128-bit vector load/store into four 32-bit RAM beats.
// Latency: store response at T+5, load response/data at T+6 after acceptance at T.
// Backpressure: stall held while busy; request must stay stable until stall drops.
module vmem_responder
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int VEC_W  = 128,
  parameter int WORD_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  data_b,
  output logic [VEC_W-1:0]  q_b,
  output logic              rsp_valid,
  output logic              stall,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              align_err
);

  localparam int BASE_W = MEM_AW - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  vmem_state_t       state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              align_q, align_d;

  logic              wload_en;
  logic              cap_en;
  logic [BEAT_W-1:0] cap_idx;
  logic [WORD_W-1:0] wsel_dat;

  // Address bits above the RAM range are ignored; word address wraps.
  logic addr_unused;
  assign addr_unused = ^req_addr[ADDR_W-1:MEM_AW+2];

  // FSM next-state, beat sequencing and per-state outputs.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    align_d   = align_q;
    wload_en  = 1'b0;
    cap_en    = 1'b0;
    cap_idx   = beat_q - BEAT_W'(1);
    rsp_valid = 1'b0;
    stall     = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall    = 1'b1;
          wload_en = req_we;
          base_d   = req_addr[MEM_AW+1:BEAT_W+2];
          beat_d   = '0;
          align_d  = align_q | misaligned(req_addr[3:0]);
          state_d  = req_we ? WR : RD;
        end
      end
      WR: begin
        stall  = 1'b1;
        mem_we = 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = RESP;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      RD: begin
        stall  = 1'b1;
        // Read data trails the address by one cycle, so beat k captures word k-1.
        cap_en = (beat_q != '0);
        if (beat_q == LAST_BEAT) begin
          state_d = RD_TAIL;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      RD_TAIL: begin
        stall   = 1'b1;
        cap_en  = 1'b1;
        cap_idx = LAST_BEAT;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, beat counter, base address and sticky alignment flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      align_q <= align_d;
    end
  end

  vmem_beat_buf #(
    .WORD_W (WORD_W),
    .VEC_W  (VEC_W)
  ) u_beat_buf (
    .clk       (clk),
    .rst       (reset),
    .wload_en  (wload_en),
    .wload_dat (data_b),
    .wsel_idx  (beat_q),
    .wsel_dat  (wsel_dat),
    .cap_en    (cap_en),
    .cap_idx   (cap_idx),
    .cap_dat   (mem_rdata),
    .rbuf_dat  (q_b)
  );

  // Beat counter parks on the last beat, so the address holds through RESP/IDLE.
  assign mem_addr  = {base_q, beat_q};
  assign mem_wdata = mem_we ? wsel_dat : '0;
  assign align_err = align_q;

endmodule

// File: tb/tb_vmem_responder.sv
module tb_vmem_responder;

  localparam int ADDR_W = 32;
  localparam int VEC_W  = 128;
  localparam int WORD_W = 32;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [VEC_W-1:0]  data_b;
  logic [VEC_W-1:0]  q_b;
  logic              rsp_valid;
  logic              stall;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              align_err;

  always #5 clk = ~clk;

  vmem_responder #(
    .ADDR_W (ADDR_W),
    .VEC_W  (VEC_W),
    .WORD_W (WORD_W),
    .MEM_AW (MEM_AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .data_b    (data_b),
    .q_b       (q_b),
    .rsp_valid (rsp_valid),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .align_err (align_err)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  // Environment RAM: synchronous single port, read data one cycle after address.
  logic [31:0] ram [DEPTH];
  logic        ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference state
  logic [31:0]  model_mem [DEPTH];
  logic [127:0] exp_q;
  bit           exp_align;
  bit           in_b2b;
  int           n_cmp = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First RAM word of the 16-byte block holding byte address a.
  function automatic int base_of(input logic [31:0] a);
    return ((int'(a / 16)) * 4) % DEPTH;
  endfunction

  function automatic logic [127:0] model_vec(input int b);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = model_mem[(b + i) % DEPTH];
    return v;
  endfunction

  // One complete access. keep=1 leaves req_valid high at the response cycle
  // so the next call forms a back-to-back request; chg=1 perturbs the request mid-access.
  task automatic access(input bit we, input logic [31:0] addr, input logic [127:0] d,
                        input bit keep, input bit chg, input string tag);
    int b, lat, nwe, nst, k, exp_lat;
    bit done;
    b = base_of(addr);
    exp_lat = (in_b2b ? 1 : 0) + (we ? 5 : 6);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    data_b    = d;
    #1;
    check({tag, ".stall_start"}, stall, in_b2b ? 0 : 1);
    lat = 0; nwe = 0; nst = 0; done = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (chg && lat == 2) begin
        req_addr = addr ^ 32'h0000_00C0;
        data_b   = {$urandom, $urandom, $urandom, $urandom};
      end
      k = lat - 1 - (in_b2b ? 1 : 0);
      if (k >= 0 && k < 4) begin
        check({tag, ".addr"}, mem_addr, 10'((b + k) % DEPTH));
        if (we) check({tag, ".wdata"}, mem_wdata, d[32*k +: 32]);
      end
      if (mem_we) nwe++;
      if (rsp_valid) done = 1;
      else if (stall) nst++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".stall_cycles"}, nst, exp_lat - 1);
    check({tag, ".stall_resp"}, stall, 0);
    check({tag, ".we_beats"}, nwe, we ? 4 : 0);
    if (we) begin
      for (int i = 0; i < 4; i++) model_mem[(b + i) % DEPTH] = d[32*i +: 32];
    end else begin
      exp_q = model_vec(b);
    end
    if (addr % 16 != 0) exp_align = 1'b1;
    check({tag, ".q_b"}, q_b, exp_q);
    check({tag, ".align_err"}, align_err, exp_align);
    if (keep) begin
      in_b2b = 1'b1;
    end else begin
      req_valid = 1'b0;
      in_b2b = 1'b0;
      @(negedge clk);
      check({tag, ".rsp_pulse"}, rsp_valid, 0);
      check({tag, ".stall_idle"}, stall, 0);
      check({tag, ".we_idle"}, mem_we, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] v1, d3, d4, d5;
    logic [31:0]  a;
    bit           we, keep;

    v1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
    exp_q = '0; exp_align = 1'b0; in_b2b = 1'b0;
    ram_init = 1'b1;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; data_b = '0;
    @(negedge clk);
    ram_init = 1'b0;
    @(negedge clk);
    check("rst.q_b", q_b, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.mem_wdata", mem_wdata, 0);
    check("rst.align_err", align_err, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.mem_we", mem_we, 0);
    check("rst.stall", stall, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed store then load of a known vector
    access(1'b1, 32'h40, v1, 1'b0, 1'b0, "t1_store");
    access(1'b0, 32'h40, '0, 1'b0, 1'b0, "t2_load");
    check("t2.vector", q_b, v1);

    // Back-to-back store/load with req_valid held high
    d3 = {$urandom, $urandom, $urandom, $urandom};
    access(1'b1, 32'h80, d3, 1'b1, 1'b0, "t3_store");
    access(1'b0, 32'h80, '0, 1'b0, 1'b0, "t3_load");
    check("t3.vector", q_b, d3);

    // Request changed mid-load
    access(1'b0, 32'h40, '0, 1'b0, 1'b1, "t6_load");
    check("t6.vector", q_b, v1);

    // Reset after two store beats
    d4 = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; data_b = d4;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t4.mem_we", mem_we, 0);
    check("t4.stall", stall, 0);
    check("t4.rsp_valid", rsp_valid, 0);
    model_mem[10'h40] = d4[31:0];
    model_mem[10'h41] = d4[63:32];
    exp_q = '0; exp_align = 1'b0; in_b2b = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) check("t4.ram", ram[10'h40 + i], model_mem[10'h40 + i]);
    check("t4.q_b", q_b, 0);

    // Misaligned store lands on the aligned block; flag is sticky
    d5 = {$urandom, $urandom, $urandom, $urandom};
    access(1'b1, 32'h44, d5, 1'b0, 1'b0, "t5_store");
    access(1'b0, 32'h40, '0, 1'b0, 1'b0, "t5_load");
    check("t5.vector", q_b, d5);
    access(1'b0, 32'h80, '0, 1'b0, 1'b0, "t5_load2");

    // Randomized mix, including back-to-back chains and misaligned addresses
    for (int n = 0; n < 40; n++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 4);
      if ($urandom_range(0, 3) == 0) a[3:0] = 4'($urandom_range(1, 15));
      we   = ($urandom_range(0, 1) == 1);
      keep = (n != 39) && ($urandom_range(0, 2) == 0);
      access(we, a, {$urandom, $urandom, $urandom, $urandom}, keep, 1'b0, "rnd");
    end

    // Sticky flag clears only on reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("end.align_err", align_err, 0);
    check("end.q_b", q_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
